base_adeser2: RTL
=================

BASE_ADESER2 -- requirements
Module: base_adeser2

Interface
REQ-001 SHALL have parameter: width, 1, bit width of one narrow beat and of each output half.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: i_v  input  1  narrow beat valid.
REQ-005 SHALL have port: i_r  output  1  narrow beat ready.
REQ-006 SHALL have port: i_d  input  width  narrow beat data.
REQ-007 SHALL have port: i_last  input  1  beat is final of its packet.
REQ-008 SHALL have port: o_v  output  1  pair valid.
REQ-009 SHALL have port: o_r  input  1  pair ready.
REQ-010 SHALL have port: o_d0  output  width  first beat of pair.
REQ-011 SHALL have port: o_d1  output  width  second beat of pair (0 when o_odd).
REQ-012 SHALL have port: o_last  output  1  pair ends a packet.
REQ-013 SHALL have port: o_odd  output  1  pair holds one beat only; d1 is padding.

Function
REQ-014 SHALL count a beat accepted only when i_v & i_r, and a pair delivered only when o_v & o_r at a rising clk edge.
REQ-015 SHALL implement four states: EMPTY, HALF (d0 captured, awaiting d1), FULL (pair held on outputs), FULL_HALF (pair held plus one pending first beat).
REQ-016 SHALL drive i_r from registered state only: 1 in EMPTY, HALF, FULL; 0 in FULL_HALF; no combinational path from o_r or i_v to i_r.
REQ-017 SHALL drive o_v = 1 exactly in FULL and FULL_HALF; o_d0/o_d1/o_last/o_odd come from registers and are stable while o_v & !o_r.
REQ-018 SHALL pack beats in arrival order: first accepted beat to o_d0, second to o_d1.
REQ-019 EMPTY: accepted beat with i_last=0 -> HALF; with i_last=1 -> FULL with o_d1=0, o_odd=1, o_last=1; no beat -> stay.
REQ-020 HALF: accepted beat -> FULL, o_d1=i_d, o_odd=0, o_last=i_last; no beat -> stay (indefinitely).
REQ-021 FULL, pair delivered, no beat -> EMPTY.
REQ-022 FULL, pair delivered, beat accepted same cycle -> treat beat as first beat per REQ-019 (HALF, or FULL with new odd pair).
REQ-023 FULL, pair not delivered, beat accepted -> FULL_HALF, storing beat data and its i_last in pending register.
REQ-024 FULL, nothing delivered or accepted -> stay, outputs unchanged.
REQ-025 FULL_HALF, pair delivered -> pending beat moves to d0; pending i_last=0 -> HALF; pending i_last=1 -> FULL with odd pair (o_d1=0, o_odd=1, o_last=1).
REQ-026 FULL_HALF, not delivered -> stay.
REQ-027 SHALL sustain one accepted beat per cycle and one delivered pair per two cycles when o_r is held 1.
REQ-028 SHALL never drop, duplicate or reorder beats under any i_v/o_r pattern.
REQ-029 SHALL not use i_d, i_last when i_v=0 and SHALL not react to o_r when o_v=0.

Reset
REQ-030 SHALL, while reset=0, asynchronously force state EMPTY, i_r=1, o_v=0, o_d0=0, o_d1=0, o_last=0, o_odd=0, pending register cleared.
REQ-031 SHALL discard any partial or held pair when reset asserts mid-operation; first beat after release is treated as o_d0.
REQ-032 SHALL accept a beat on the first rising clk edge after reset deasserts.

Verification
REQ-033 Stream, o_r=1: beats A,B,C,D (i_last on D) in 4 consecutive cycles -> pairs {A,B} last=0, {C,D} last=1, each o_v 1 cycle after second beat, i_r stays 1.
REQ-034 Backpressure: o_r=0, beats A,B,C -> state FULL_HALF, i_r=0, o_v=1 {A,B} held stable; raise o_r -> {A,B} delivered, state HALF holding C, i_r=1.
REQ-035 Odd packet: single beat 0x5 with i_last from EMPTY -> next cycle o_v=1, o_d0=0x5, o_d1=0, o_odd=1, o_last=1.
REQ-036 Pending odd: FULL with o_r=0, accept E with i_last -> FULL_HALF; o_r=1 one cycle -> state FULL with {E,0} odd=1 last=1.
REQ-037 Reset mid-pair: accept A (HALF), pull reset low between edges -> o_v=0, i_r=1 immediately; after release beats F,G -> pair {F,G}.
REQ-038 Random i_v/o_r (10k cycles, width=8) vs. scoreboard -> every beat delivered once, in order, pairing and o_odd/o_last correct.

Source files
------------

// File: rtl/base_adeser2.sv
// Packs narrow beats into pairs (d0 = first, d1 = second); a packet-final beat in d0 yields an odd pair.
// A pair is valid one cycle after its last beat is accepted; i_r drops only while one pair plus one beat are held.
module base_adeser2 #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    input  logic             i_last,
    output logic             o_v,
    input  logic             o_r,
    output logic [width-1:0] o_d0,
    output logic [width-1:0] o_d1,
    output logic             o_last,
    output logic             o_odd
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HALF      = 2'd1,
        FULL      = 2'd2,
        FULL_HALF = 2'd3
    } state_t;

    state_t             state;
    logic [width-1:0]   pend_d;
    logic               pend_last;
    logic               acc;
    logic               dlv;

    // Handshake qualifiers are decoded purely from registered state.
    assign i_r = (state != FULL_HALF);
    assign o_v = (state == FULL) || (state == FULL_HALF);
    assign acc = i_v && i_r;
    assign dlv = o_v && o_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            o_d0      <= '0;
            o_d1      <= '0;
            o_last    <= 1'b0;
            o_odd     <= 1'b0;
            pend_d    <= '0;
            pend_last <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        o_d0 <= i_d;
                        if (i_last) begin
                            o_d1   <= '0;
                            o_odd  <= 1'b1;
                            o_last <= 1'b1;
                            state  <= FULL;
                        end else begin
                            state  <= HALF;
                        end
                    end
                end
                HALF: begin
                    if (acc) begin
                        o_d1   <= i_d;
                        o_odd  <= 1'b0;
                        o_last <= i_last;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (dlv && acc) begin
                        // Output slot frees this cycle, so the new beat starts the next pair.
                        o_d0 <= i_d;
                        if (i_last) begin
                            o_d1   <= '0;
                            o_odd  <= 1'b1;
                            o_last <= 1'b1;
                            state  <= FULL;
                        end else begin
                            state  <= HALF;
                        end
                    end else if (dlv) begin
                        state <= EMPTY;
                    end else if (acc) begin
                        pend_d    <= i_d;
                        pend_last <= i_last;
                        state     <= FULL_HALF;
                    end
                end
                FULL_HALF: begin
                    if (dlv) begin
                        o_d0 <= pend_d;
                        if (pend_last) begin
                            o_d1   <= '0;
                            o_odd  <= 1'b1;
                            o_last <= 1'b1;
                            state  <= FULL;
                        end else begin
                            state  <= HALF;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
